// File: rtl/seq_pkg.sv
// Shared definitions for the term generator and checker: widths, seeds, FSM states, recurrence.
// Latency: n/a (types, constants and a pure combinational function).
// Backpressure: n/a.
//
// next_term() is the single definition of a(n) = a(n-2) + a(n-3). Its result is one bit
// wider than the terms so callers can see the carry out of the WIDTH-bit sum.
package seq_pkg;

    localparam int DEF_WIDTH = 32;

    localparam logic [DEF_WIDTH-1:0] DEF_SEED0 = '0;
    localparam logic [DEF_WIDTH-1:0] DEF_SEED1 = DEF_WIDTH'(1);
    localparam logic [DEF_WIDTH-1:0] DEF_SEED2 = DEF_WIDTH'(1);

    typedef enum logic [1:0] {
        SEED  = 2'd0,
        CHECK = 2'd1,
        HALT  = 2'd2
    } state_e;

    function automatic logic [DEF_WIDTH:0] next_term(
        input logic [DEF_WIDTH-1:0] h2,
        input logic [DEF_WIDTH-1:0] h3
    );
        return {1'b0, h2} + {1'b0, h3};
    endfunction

endpackage

// File: rtl/seq_checker_if.sv
// Term stream from the generator into the checker.
// Latency: n/a (wires only).
// Backpressure: none; the consumer accepts every valid term.
//
// seq_i       : term value
// seq_valid_i : seq_i carries a new term this cycle
// The _i names are kept because they are the checker's input ports.
interface seq_checker_if #(
    parameter int WIDTH = seq_pkg::DEF_WIDTH
);
    logic [WIDTH-1:0] seq_i;
    logic             seq_valid_i;

    modport master (output seq_i, output seq_valid_i);
    modport slave  (input  seq_i, input  seq_valid_i);
endinterface

// File: rtl/seq_ref_model.sv
// Expected-term generator: seed sequencing plus h1/h2/h3 history of the recurrence.
// Latency: exp_o/carry_o are combinational from registered history; history advances on adv_i.
// Backpressure: none; advances only when the checker accepts a term.
//
// Ports: clk, reset (sync, active-high), flush_i (sync restart), adv_i (a term was accepted),
//        exp_o (expected value of the current term), carry_o (sum overflowed WIDTH bits),
//        seed_last_o (the current term is the last seed).
module seq_ref_model
    import seq_pkg::*;
#(
    parameter int               WIDTH = DEF_WIDTH,
    parameter logic [WIDTH-1:0] SEED0 = DEF_SEED0,
    parameter logic [WIDTH-1:0] SEED1 = DEF_SEED1,
    parameter logic [WIDTH-1:0] SEED2 = DEF_SEED2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush_i,
    input  logic             adv_i,
    output logic [WIDTH-1:0] exp_o,
    output logic             carry_o,
    output logic             seed_last_o
);

    logic [WIDTH-1:0] h1_q, h2_q, h3_q;
    // 0..2 while the seeds are being consumed, 3 once the recurrence is live.
    logic [1:0]       seed_idx_q;
    logic [WIDTH:0]   sum;

    assign sum = next_term(h2_q, h3_q);

    always_comb begin
        exp_o   = sum[WIDTH-1:0];
        carry_o = sum[WIDTH];
        case (seed_idx_q)
            2'd0: begin exp_o = SEED0; carry_o = 1'b0; end
            2'd1: begin exp_o = SEED1; carry_o = 1'b0; end
            2'd2: begin exp_o = SEED2; carry_o = 1'b0; end
            default: ;
        endcase
    end

    assign seed_last_o = (seed_idx_q == 2'd2);

    // History is fed from the expected value, never the received term, so a single
    // corrupted input cannot poison later expectations.
    always_ff @(posedge clk) begin
        if (reset || flush_i) begin
            h1_q       <= '0;
            h2_q       <= '0;
            h3_q       <= '0;
            seed_idx_q <= 2'd0;
        end else if (adv_i) begin
            h3_q <= h2_q;
            h2_q <= h1_q;
            h1_q <= exp_o;
            if (seed_idx_q != 2'd3) begin
                seed_idx_q <= seed_idx_q + 2'd1;
            end
        end
    end

endmodule

// File: rtl/seq_checker.sv
// On-the-fly checker of the generator's term stream against a(n) = a(n-2) + a(n-3).
// Latency: pass_o/fail_o and all counters update one cycle after the accepting edge.
// Backpressure: none; every valid term is accepted except in HALT, where terms are dropped.
//
// Ports: clk, reset (sync, active-high), seq_if (slave: seq_i, seq_valid_i), clear_i (sync restart),
//        pass_o/fail_o (result pulses), err_cnt_o, first_err_idx_o, term_cnt_o (saturating),
//        wrap_o (sticky overflow of the expected sum), halted_o (in HALT).
// WIDTH must match seq_pkg::DEF_WIDTH since the shared recurrence function is fixed-width.
module seq_checker
    import seq_pkg::*;
#(
    parameter int               WIDTH     = DEF_WIDTH,
    parameter int               CNT_W     = 16,
    parameter logic [WIDTH-1:0] SEED0     = DEF_SEED0,
    parameter logic [WIDTH-1:0] SEED1     = DEF_SEED1,
    parameter logic [WIDTH-1:0] SEED2     = DEF_SEED2,
    parameter int               ERR_LIMIT = 0
) (
    input  logic             clk,
    input  logic             reset,
    seq_checker_if.slave     seq_if,
    input  logic             clear_i,
    output logic             pass_o,
    output logic             fail_o,
    output logic [CNT_W-1:0] err_cnt_o,
    output logic [CNT_W-1:0] first_err_idx_o,
    output logic [CNT_W-1:0] term_cnt_o,
    output logic             wrap_o,
    output logic             halted_o
);

    localparam logic [CNT_W-1:0] ERR_LIM_C = CNT_W'(ERR_LIMIT);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] n_q, n_d;           // term index; doubles as the accepted-term count
    logic [CNT_W-1:0] err_q, err_d;
    logic [CNT_W-1:0] first_q, first_d;
    logic             wrap_q, wrap_d;
    logic             pass_q, pass_d;
    logic             fail_q, fail_d;

    logic             accept;
    logic             mismatch;
    logic [WIDTH-1:0] exp_term;
    logic             exp_carry;
    logic             seed_last;

    assign accept   = seq_if.seq_valid_i && (state_q != HALT);
    assign mismatch = (seq_if.seq_i != exp_term);

    seq_ref_model #(
        .WIDTH (WIDTH),
        .SEED0 (SEED0),
        .SEED1 (SEED1),
        .SEED2 (SEED2)
    ) u_ref (
        .clk         (clk),
        .reset       (reset),
        .flush_i     (clear_i),
        .adv_i       (accept),
        .exp_o       (exp_term),
        .carry_o     (exp_carry),
        .seed_last_o (seed_last)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset || clear_i) begin
            state_q <= SEED;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state. Halting uses the post-increment error count so the term that
    // reaches the limit is still reported before checking stops.
    always_comb begin
        state_d = state_q;
        case (state_q)
            SEED:    if (accept && seed_last) state_d = CHECK;
            CHECK:   ;
            HALT:    ;
            default: state_d = SEED;
        endcase
        if (accept && mismatch && (ERR_LIMIT != 0) && (err_d == ERR_LIM_C)) begin
            state_d = HALT;
        end
    end

    // Output / datapath next values
    always_comb begin
        pass_d  = 1'b0;
        fail_d  = 1'b0;
        n_d     = n_q;
        err_d   = err_q;
        first_d = first_q;
        wrap_d  = wrap_q;
        if (accept) begin
            pass_d = ~mismatch;
            fail_d = mismatch;
            n_d    = (&n_q) ? n_q : n_q + 1'b1;
            if (exp_carry) begin
                wrap_d = 1'b1;
            end
            if (mismatch) begin
                if (err_q == '0) begin
                    first_d = n_q;
                end
                err_d = (&err_q) ? err_q : err_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset || clear_i) begin
            n_q     <= '0;
            err_q   <= '0;
            first_q <= '0;
            wrap_q  <= 1'b0;
            pass_q  <= 1'b0;
            fail_q  <= 1'b0;
        end else begin
            n_q     <= n_d;
            err_q   <= err_d;
            first_q <= first_d;
            wrap_q  <= wrap_d;
            pass_q  <= pass_d;
            fail_q  <= fail_d;
        end
    end

    assign pass_o          = pass_q;
    assign fail_o          = fail_q;
    assign err_cnt_o       = err_q;
    assign first_err_idx_o = first_q;
    assign term_cnt_o      = n_q;
    assign wrap_o          = wrap_q;
    assign halted_o        = (state_q == HALT);

endmodule
